serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder that time-multiplexes a single one-bit full-adder cell across a `WIDTH`-bit operand pair, one bit per clock, LSB first. It stores the carry in a flip-flop between bits. It sits directly downstream of the one-bit full-adder cell and is the first sequential datapath stage built on it. It uses a start/done handshake toward the controlling logic.

## Interface
- `WIDTH`, 8, operand and result width in bits (≥ 2)
- `clk` input 1, rising-edge clock
- `rst` input 1, reset, asynchronous, active-high
- `start` input 1, request an addition; sampled only in IDLE
- `a` input WIDTH, operand A; captured on the accepting edge
- `b` input WIDTH, operand B; captured on the accepting edge
- `c_in` input 1, carry-in; captured on the accepting edge
- `busy` output 1, high while bits are being processed
- `done` output 1, one-cycle pulse when the result is valid
- `sum` output WIDTH, registered result; held until the next result
- `c_out` output 1, registered carry-out; held with `sum`
- `ovf` output 1, signed overflow (present only with `SERIAL_ADDER_OVF_EN`)

## Operation
- One clock domain. Reset is asynchronous and active-high.
- States:
  - IDLE: waits for `start`.
  - SHIFT: processes one bit per cycle.
  - DONE: presents the result for one cycle.
- IDLE → SHIFT when `start`=1 on an edge. That edge does the following:
  - loads `a` and `b` into shift registers.
  - loads the carry flop with `c_in`.
  - clears the bit counter to 0.
- Each SHIFT edge does the following:
  - feeds the LSB of the A register, the LSB of the B register and the carry flop into the FA cell.
  - shifts the FA sum bit into the MSB of a partial-sum register, which moves right.
  - updates the carry flop with the FA carry.
  - shifts A and B right by one.
  - increments the counter.
- SHIFT → DONE on the edge that processes bit WIDTH-1 (counter == WIDTH-1). That same edge does the following:
  - copies the completed partial sum into `sum`.
  - copies the final carry into `c_out`.
- DONE → IDLE unconditionally on the next edge.
- `start` is ignored in SHIFT and DONE. There is no queuing; a request during those states is dropped.
- Arithmetic is unsigned modulo 2^WIDTH, and `c_out` is bit WIDTH of a + b + c_in.
- Counter width is $clog2(WIDTH). Its terminal value is WIDTH-1. Bit WIDTH-1 is processed, then the counter wraps to 0 in DONE.

## Timing
- Reset values:
  - state = IDLE
  - `busy`=0, `done`=0
  - `sum`=0, `c_out`=0, `ovf`=0
  - shift, counter and carry registers = 0
- If `start` is accepted at edge k:
  - `busy`=1 from after edge k until after edge k+WIDTH.
  - `done`=1 for exactly the cycle between edges k+WIDTH and k+WIDTH+1.
  - `sum`/`c_out` update at edge k+WIDTH.
- Latency is WIDTH+1 edges from start to the done sample.
- Throughput is one addition per WIDTH+2 cycles if `start` is held high continuously. It is re-accepted in IDLE at edge k+WIDTH+2.
- `sum`/`c_out` never change mid-operation; the previous result stays visible while `busy`.
- `rst` mid-operation aborts immediately to IDLE and clears all outputs. The aborted result is never presented.
- `busy` and `done` are never high together.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined:
  - adds the `ovf` port and one register.
  - at the SHIFT→DONE edge, `ovf` = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - `ovf` is held with `sum` and reset to 0.
- `SERIAL_ADDER_OVF_EN` undefined: the port and register are absent, and all other behaviour is identical.

## Structure
- Package `serial_adder_pkg`:
  - state enum (IDLE, SHIFT, DONE), 2-bit encoding.
  - default width constant `SERIAL_ADDER_WIDTH_DEF` = 8.
- One sub-module, `fa_bit`: combinational one-bit full adder (a, b, c_in → sum, c_out) instantiated once. No other hierarchy.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, c_in=0, start pulse → `done` 9 edges after acceptance; `sum`=0x96, `c_out`=0.
- a=0xFF, b=0x01, c_in=0 → `sum`=0x00, `c_out`=1; with the macro, `ovf`=0.
- a=0xFF, b=0xFF, c_in=1 → `sum`=0xFF, `c_out`=1.
- `start` re-pulsed with new operands while `busy` → ignored; result equals the first operation, and `done` pulses once.
- `rst` asserted 4 cycles into SHIFT → next cycle `busy`=0, `sum`=0, `c_out`=0; no `done` pulse; a fresh start then computes 0x10+0x20 → 0x30.
- With `SERIAL_ADDER_OVF_EN`, a=0x7F, b=0x01, c_in=0 → `sum`=0x80, `c_out`=0, `ovf`=1; then 0x80+0x80 → `sum`=0x00, `c_out`=1, `ovf`=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned SERIAL_ADDER_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/fa_bit.sv
// Combinational one-bit full adder cell.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic w_p;

    assign w_p   = a ^ b;
    assign sum   = w_p ^ c_in;
    assign c_out = (a & b) | (c_in & w_p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused across WIDTH bits, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_ADDER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_psum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c_out;
    logic               w_fa_sum;
    logic               w_fa_cout;
    logic               w_last;

    fa_bit u_fa_bit (
        .a     (r_a[0]),
        .b     (r_b[0]),
        .c_in  (r_carry),
        .sum   (w_fa_sum),
        .c_out (w_fa_cout)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Datapath and registered status; result registers only move on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == SHIFT);
            r_done <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_psum  <= {w_fa_sum, r_psum[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_sum   <= {w_fa_sum, r_psum[WIDTH-1:1]};
                        r_c_out <= w_fa_cout;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           r_ovf <= 1'b0;
        else if (r_state == SHIFT && w_last) r_ovf <= r_carry ^ w_fa_cout;
    end

    assign ovf = r_ovf;
`endif

    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder; build with +define+SERIAL_ADDER_OVF_EN to cover ovf.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             o;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    exp_t             q[$];
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_mis = 0;
    logic [WIDTH-1:0] last_sum = '0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (busy && done) check("busy_done_overlap", 1, 0);
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("sum",        int'(sum),   int'(e.sum));
                    check("c_out",      int'(c_out), int'(e.c));
                    check("done_cycle", cyc,         e.cyc);
`ifdef SERIAL_ADDER_OVF_EN
                    check("ovf",        int'(ovf),   int'(e.o));
`endif
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) check("idle_timeout", 1, 0);
    endtask

    task automatic do_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tc, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo, input bit poke);
        int n = 0;
        wait_idle();
        start = 1'b1; a = ta; b = tb_; c_in = tc;
        @(posedge clk); #1;
        q.push_back('{es, ec, eo, cyc + WIDTH});
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        check("sum_held",          int'(sum),  int'(last_sum));
        if (poke) begin
            start = 1'b1; a = 8'hAA; b = 8'hAA; c_in = 1'b1;
            repeat (2) @(negedge clk);
            start = 1'b0;
        end
        while (q.size() != 0 && n < int'(WIDTH) + 4) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("done_timeout", 1, 0);
            q.delete();
        end
        last_sum = es;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",  int'(busy),  0);
        check("rst_done",  int'(done),  0);
        check("rst_sum",   int'(sum),   0);
        check("rst_c_out", int'(c_out), 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf",   int'(ovf),   0);
`endif
        rst = 1'b0;

        do_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);

        // Abort four cycles into SHIFT; no result may appear afterwards
        wait_idle();
        start = 1'b1; a = 8'h44; b = 8'h11; c_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",  int'(busy),  0);
        check("abort_done",  int'(done),  0);
        check("abort_sum",   int'(sum),   0);
        check("abort_c_out", int'(c_out), 0);
        rst = 1'b0;
        last_sum = '0;
        repeat (WIDTH + 3) @(negedge clk);

        do_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        repeat (WIDTH + 3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
